// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - pipeline request/response and data-memory bus of the load/store unit
interface load_store_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_load;
   logic              req_store;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] store_data;
   logic              busy;
   logic              resp_valid;
   logic [DATA_W-1:0] load_data;
   logic              misaligned;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  req_valid, req_load, req_store, funct3, addr, store_data, mem_read_data,
      output busy, resp_valid, load_data, misaligned,
             mem_read, mem_write, mem_address, mem_write_data
   );

   modport master (
      output req_valid, req_load, req_store, funct3, addr, store_data, mem_read_data,
      input  busy, resp_valid, load_data, misaligned,
             mem_read, mem_write, mem_address, mem_write_data
   );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit over a word-only memory, read-modify-write for SB/SH
// Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN
module load_store_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic               clk,
   input logic               rst_n,
   load_store_unit_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, RD, RWAIT, MERGE_WR, WR, RESP} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   state_t            state, state_nx;
   size_t             size_in, size_q;
   logic              accept;
   logic              mis_in;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] sdata_q;
   logic              load_q;
   logic              uns_q;
   logic [DATA_W-1:0] load_data_q;
   logic [DATA_W-1:0] wdata_q;
   logic [4:0]        shamt;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;
   logic [DATA_W-1:0] load_fmt;
   logic [DATA_W-1:0] merged;

   assign accept = (state == IDLE) && bus.req_valid && (bus.req_load || bus.req_store);

   // Loads use funct3[1:0] for size (bit 2 = unsigned); stores only know SB/SH, rest is SW
   always_comb begin
      size_in = SZ_W;
      if (bus.req_load) begin
         case (bus.funct3[1:0])
            2'b00:   size_in = SZ_B;
            2'b01:   size_in = SZ_H;
            default: size_in = SZ_W;
         endcase
      end else begin
         case (bus.funct3)
            3'b000:  size_in = SZ_B;
            3'b001:  size_in = SZ_H;
            default: size_in = SZ_W;
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;

   assign mis_in = ((size_in == SZ_H) && bus.addr[0]) ||
                   ((size_in == SZ_W) && (bus.addr[1:0] != 2'b00));
   assign bus.misaligned = (state == RESP) && mis_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      mis_q <= 1'b0;
      else if (accept) mis_q <= mis_in;
   end
`else
   assign mis_in         = 1'b0;
   assign bus.misaligned = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (mis_in)                 state_nx = RESP;
               else if (bus.req_load)      state_nx = RD;
               else if (size_in == SZ_W)   state_nx = WR;
               else                        state_nx = RD;
            end
         end
         RD:       state_nx = RWAIT;
         RWAIT:    state_nx = load_q ? RESP : MERGE_WR;
         MERGE_WR: state_nx = RESP;
         WR:       state_nx = RESP;
         RESP:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   assign shamt     = {addr_q[1:0], 3'b000};
   assign byte_lane = 8'(bus.mem_read_data >> shamt);
   assign half_lane = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

   always_comb begin
      load_fmt = bus.mem_read_data;
      case (size_q)
         SZ_B:    load_fmt = uns_q ? {{(DATA_W-8){1'b0}}, byte_lane}
                                   : {{(DATA_W-8){byte_lane[7]}}, byte_lane};
         SZ_H:    load_fmt = uns_q ? {{(DATA_W-16){1'b0}}, half_lane}
                                   : {{(DATA_W-16){half_lane[15]}}, half_lane};
         default: load_fmt = bus.mem_read_data;
      endcase
   end

   // Splice the new byte/half into the word just read back
   always_comb begin
      merged = sdata_q;
      case (size_q)
         SZ_B: merged = (bus.mem_read_data & ~({{(DATA_W-8){1'b0}}, 8'hFF} << shamt)) |
                        ({{(DATA_W-8){1'b0}}, sdata_q[7:0]} << shamt);
         SZ_H: merged = addr_q[1] ? {sdata_q[15:0], bus.mem_read_data[15:0]}
                                  : {bus.mem_read_data[31:16], sdata_q[15:0]};
         default: merged = sdata_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr_q      <= '0;
         sdata_q     <= '0;
         load_q      <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= SZ_W;
         load_data_q <= '0;
         wdata_q     <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            addr_q      <= bus.addr;
            sdata_q     <= bus.store_data;
            load_q      <= bus.req_load;
            uns_q       <= bus.funct3[2];
            size_q      <= size_in;
            load_data_q <= '0;
            if (!bus.req_load && (size_in == SZ_W))
               wdata_q <= bus.store_data;
         end
         if (state == RWAIT) begin
            if (load_q) load_data_q <= load_fmt;
            else        wdata_q     <= merged;
         end
      end
   end

   assign bus.busy           = (state != IDLE);
   assign bus.resp_valid     = (state == RESP);
   assign bus.mem_read       = (state == RD);
   assign bus.mem_write      = (state == WR) || (state == MERGE_WR);
   assign bus.mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.mem_write_data = wdata_q;
   assign bus.load_data      = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic mem_load;
   logic [31:0] mem [0:63];
   int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
   logic [31:0] rd_addr_last = '0, wr_addr_last = '0, wr_data_last = '0;
   int checks = 0, errors = 0;

   load_store_unit_if bus();
   load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[16] <= 32'h8899AABB;
      end else if (bus.mem_write) begin
         mem[bus.mem_address[7:2]] <= bus.mem_write_data;
      end
      if (bus.mem_read) begin
         bus.mem_read_data <= mem[bus.mem_address[7:2]];
         rd_cnt            <= rd_cnt + 1;
         rd_addr_last      <= bus.mem_address;
      end
      if (bus.mem_write) begin
         wr_cnt       <= wr_cnt + 1;
         wr_addr_last <= bus.mem_address;
         wr_data_last <= bus.mem_write_data;
      end
      if (bus.mem_read && bus.mem_write) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      bus.req_valid  = 1'b1;
      bus.req_load   = ld;
      bus.req_store  = st;
      bus.funct3     = f3;
      bus.addr       = a;
      bus.store_data = d;
   endtask

   task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] ldat, output logic mis);
      issue(ld, st, f3, a, d);
      tick();
      bus.req_valid = 1'b0;
      lat = 1;
      while (bus.resp_valid !== 1'b1 && lat < 16) begin
         tick();
         lat++;
      end
      ldat = bus.load_data;
      mis  = bus.misaligned;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int r0, w0;
      logic [31:0] ld;
      logic mis;

      bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0;
      bus.funct3 = 3'b000; bus.addr = '0; bus.store_data = '0;
      mem_load = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'b0, bus.busy}, 32'h0);
      check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      check("rst_mem_read", {31'b0, bus.mem_read}, 32'h0);
      check("rst_mem_write", {31'b0, bus.mem_write}, 32'h0);
      check("rst_misaligned", {31'b0, bus.misaligned}, 32'h0);
      check("rst_load_data", bus.load_data, 32'h0);
      check("rst_mem_address", bus.mem_address, 32'h0);
      check("rst_mem_write_data", bus.mem_write_data, 32'h0);
      mem_load = 1'b0;
      rst_n = 1'b1;
      tick();

      issue(1'b0, 1'b0, 3'b000, 32'h40, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      check("noop_busy", {31'b0, bus.busy}, 32'h0);
      check("noop_mem_read", {31'b0, bus.mem_read}, 32'h0);

      r0 = rd_cnt; w0 = wr_cnt;
      access(1'b1, 1'b0, 3'b000, 32'h41, 32'h0, lat, ld, mis);
      check("lb_latency", 32'(lat), 32'd3);
      check("lb_data", ld, 32'hFFFFFFAA);
      check("lb_reads", 32'(rd_cnt - r0), 32'd1);
      check("lb_writes", 32'(wr_cnt - w0), 32'd0);
      check("lb_rd_addr", rd_addr_last, 32'h40);
      check("lb_misaligned", {31'b0, mis}, 32'h0);
      check("lb_idle_busy", {31'b0, bus.busy}, 32'h0);

      access(1'b1, 1'b0, 3'b101, 32'h42, 32'h0, lat, ld, mis);
      check("lhu_data", ld, 32'h00008899);
      access(1'b1, 1'b0, 3'b001, 32'h42, 32'h0, lat, ld, mis);
      check("lh_data", ld, 32'hFFFF8899);
      access(1'b1, 1'b0, 3'b100, 32'h43, 32'h0, lat, ld, mis);
      check("lbu_data", ld, 32'h00000088);
      access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, lat, ld, mis);
      check("lw_data", ld, 32'h8899AABB);

      r0 = rd_cnt; w0 = wr_cnt;
      access(1'b0, 1'b1, 3'b000, 32'h43, 32'h5C, lat, ld, mis);
      check("sb_latency", 32'(lat), 32'd4);
      check("sb_reads", 32'(rd_cnt - r0), 32'd1);
      check("sb_writes", 32'(wr_cnt - w0), 32'd1);
      check("sb_wr_data", wr_data_last, 32'h5C99AABB);
      check("sb_wr_addr", wr_addr_last, 32'h40);
      check("sb_load_data", ld, 32'h0);

      issue(1'b0, 1'b1, 3'b010, 32'h80, 32'h12345678);
      tick();
      check("sw_mem_write", {31'b0, bus.mem_write}, 32'h1);
      check("sw_wr_data", bus.mem_write_data, 32'h12345678);
      check("sw_mem_address", bus.mem_address, 32'h80);
      issue(1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
      tick();
      check("sw_resp_valid", {31'b0, bus.resp_valid}, 32'h1);
      check("sw_resp_busy", {31'b0, bus.busy}, 32'h1);
      tick();
      check("b2b_idle_busy", {31'b0, bus.busy}, 32'h0);
      check("b2b_idle_mem_read", {31'b0, bus.mem_read}, 32'h0);
      tick();
      bus.req_valid = 1'b0;
      check("b2b_mem_read", {31'b0, bus.mem_read}, 32'h1);
      check("b2b_mem_address", bus.mem_address, 32'h80);
      tick();
      tick();
      check("b2b_resp_valid", {31'b0, bus.resp_valid}, 32'h1);
      check("b2b_load_data", bus.load_data, 32'h12345678);
      tick();

      w0 = wr_cnt;
      issue(1'b0, 1'b1, 3'b001, 32'h42, 32'h0000BEEF);
      tick();
      bus.req_valid = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", {31'b0, bus.busy}, 32'h0);
      check("arst_mem_read", {31'b0, bus.mem_read}, 32'h0);
      check("arst_mem_write", {31'b0, bus.mem_write}, 32'h0);
      check("arst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
      check("arst_mem_address", bus.mem_address, 32'h0);
      check("arst_mem_write_data", bus.mem_write_data, 32'h0);
      check("arst_load_data", bus.load_data, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("arst_release_busy", {31'b0, bus.busy}, 32'h0);
      check("arst_no_write", 32'(wr_cnt - w0), 32'd0);
      access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, lat, ld, mis);
      check("arst_word_intact", ld, 32'h5C99AABB);

      r0 = rd_cnt;
      access(1'b1, 1'b0, 3'b010, 32'h42, 32'h0, lat, ld, mis);
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis_latency", 32'(lat), 32'd1);
      check("mis_flag", {31'b0, mis}, 32'h1);
      check("mis_load_data", ld, 32'h0);
      check("mis_reads", 32'(rd_cnt - r0), 32'd0);
`else
      check("mis_latency", 32'(lat), 32'd3);
      check("mis_flag", {31'b0, mis}, 32'h0);
      check("mis_load_data", ld, 32'h5C99AABB);
      check("mis_reads", 32'(rd_cnt - r0), 32'd1);
      check("mis_rd_addr", rd_addr_last, 32'h40);
`endif
      check("rd_wr_overlap", 32'(both_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and the word-only data memory.
- Turns RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses on the memory side.
- Loads: the selected byte or halfword is extracted and sign- or zero-extended.
- Sub-word stores: a read-modify-write sequence, because the memory only writes full words.
- Asserts busy while a request is in flight so the pipeline stalls.

Parameters:
- ADDR_W, 32, width of the byte address on both sides.
- DATA_W, 32, data word width; fixed at 32 for RV32I.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_load  input  1  request is a load
- req_store  input  1  request is a store; ignored if req_load=1
- funct3  input  3  RISC-V funct3 of the access
- addr  input  32  byte address
- store_data  input  32  store source; low byte/half used for SB/SH
- busy  output  1  high while not IDLE; pipeline holds the request
- resp_valid  output  1  one-cycle pulse when the access completes
- load_data  output  32  formatted load result; valid with resp_valid
- misaligned  output  1  qualifies resp_valid (see Optional Feature)
- mem_read  output  1  to data memory
- mem_write  output  1  to data memory
- mem_address  output  32  word-aligned: addr[31:2],2'b00
- mem_write_data  output  32  full word to write
- mem_read_data  input  32  memory read port; valid the cycle after mem_read is sampled high

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - busy, resp_valid, mem_read, mem_write, misaligned = 0.
  - load_data, mem_address, mem_write_data = 0.
- Accept: at a rising edge in IDLE with req_valid=1 and (req_load|req_store)=1.
  - addr, funct3, store_data and the kind of access are latched.
  - Inputs are ignored while busy=1.
  - A req_valid with neither load nor store set does nothing.
- FSM states: IDLE, RD, RWAIT, MERGE_WR, WR, RESP.
- Load: IDLE->RD->RWAIT->RESP->IDLE.
  - RD: mem_read=1.
  - RWAIT: mem_read_data sampled; byte lane addr[1:0] (or half lane addr[1]) extracted; load_data registered.
  - RESP: resp_valid=1.
  - Latency: resp_valid in the 3rd cycle after the accept edge.
- Load extension:
  - LB sign-extends bit 7 of the lane; LH sign-extends bit 15.
  - LBU and LHU zero-extend.
  - LW passes the word.
  - funct3 011, 110 and 111 are treated as LW.
- SW: IDLE->WR->RESP.
  - WR: mem_write=1 with mem_write_data=store_data.
  - resp_valid pulses in the 2nd cycle after accept; load_data=0.
- SB/SH: IDLE->RD->RWAIT->MERGE_WR->RESP.
  - RWAIT: the read word is captured.
  - MERGE_WR: mem_write=1. The data is the captured word with byte lane addr[1:0] (SB) or half lane addr[1] (SH) replaced by store_data[7:0] or store_data[15:0].
  - Store funct3 values other than 000 and 001 are treated as SW.
- mem_read and mem_write are never high in the same cycle; each is high for exactly one cycle per access.
- mem_address is held stable from RD/WR through the end of RESP.
- busy is high in every non-IDLE state and drops combinationally in RESP's following IDLE cycle. A new request is accepted on the first edge with the FSM in IDLE, so back-to-back accesses have one IDLE cycle between them.
- Reset mid-operation forces IDLE immediately. No partial write is issued after rst_n falls; a write already sampled by memory stands.
- Address wrap: none; mem_address is a pure truncation.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - An access is misaligned if LH/LHU/SH has addr[0]=1, or LW/SW has addr[1:0]!=0.
  - A misaligned access goes IDLE->RESP with no mem_read or mem_write.
  - RESP shows resp_valid=1, misaligned=1, load_data=0.
- Not defined:
  - misaligned is tied 0.
  - Halfword lane select uses addr[1] only; words ignore addr[1:0].

Test Plan:
- Memory word 0x40 = 0x8899AABB; LB at addr 0x41 -> mem_read once at address 0x40; resp_valid 3 cycles after accept; load_data=0xFFFFFFAA.
- Same word; LHU at addr 0x42 -> load_data=0x00008899; LH at addr 0x42 -> load_data=0xFFFF8899.
- SB 0x5C to addr 0x43, word=0x8899AABB -> one mem_read then one mem_write of 0x5C99AABB to address 0x40; resp_valid one cycle later; mem_read and mem_write never coincide.
- SW 0x12345678 to addr 0x80, then LW addr 0x80 presented while busy -> the load is accepted only after IDLE and returns 0x12345678.
- rst_n pulled low during RWAIT of an SH -> all outputs 0 asynchronously; no mem_write; state IDLE after release.
- With LSU_MISALIGN_TRAP_EN, LW at addr 0x42 -> no memory access; resp_valid=1 and misaligned=1 the cycle after accept. Without the macro -> reads word 0x40 normally and misaligned=0.
